// File: rtl/simple.sv
// Registered, glitch-filtered 3-input Boolean function unit.
// The output is TRUTH_TABLE[{a,b,c}], committed only after the inputs have held for STABLE_CYCLES clocks.
module simple #(
  parameter logic [7:0]  TRUTH_TABLE   = 8'hE8,
  parameter int unsigned STABLE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic out
);

  localparam int CNT_W = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [2:0]       w_in;
  logic             w_stable;
  logic [2:0]       r_in_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;

  assign w_in     = {a, b, c};
  assign w_stable = (r_cnt == CNT_MAX);

  // Stage 1 captures the inputs and counts how long they have held;
  // stage 2 commits the function result once the hold count is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q <= 3'b000;
      r_cnt  <= '0;
      r_out  <= 1'b0;
    end else begin
      r_in_q <= w_in;
      if (w_in != r_in_q) begin
        r_cnt <= '0;
      end else if (!w_stable) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_stable) begin
        r_out <= TRUTH_TABLE[r_in_q];
      end
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_simple.sv
// Bench for simple: majority, XOR3 and filtered-majority instances driven from shared inputs,
// checked against fixed vectors, hand-written corner sequences and a run-length reference model.
module tb_simple;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_abc;
  logic       o_maj;
  logic       o_xor;
  logic       o_flt;

  int vectors;
  int miscompares;

  simple u_maj (
    .clk(clk), .rst_n(rst_n), .a(in_abc[2]), .b(in_abc[1]), .c(in_abc[0]), .out(o_maj)
  );

  simple #(.TRUTH_TABLE(8'h96), .STABLE_CYCLES(0)) u_xor (
    .clk(clk), .rst_n(rst_n), .a(in_abc[2]), .b(in_abc[1]), .c(in_abc[0]), .out(o_xor)
  );

  simple #(.TRUTH_TABLE(8'hE8), .STABLE_CYCLES(3)) u_flt (
    .clk(clk), .rst_n(rst_n), .a(in_abc[2]), .b(in_abc[1]), .c(in_abc[0]), .out(o_flt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, the last sampled pattern and how many
  // consecutive edges it has been sampled (the reset state counts as one).
  logic [2:0]  m_prev [3];
  int unsigned m_run  [3];
  logic        m_out  [3];
  int unsigned m_hold [3];

  function automatic logic func_of(int d, logic [2:0] x);
    int ones;
    ones = int'(x[2]) + int'(x[1]) + int'(x[0]);
    if (d == 1) return logic'(ones % 2);
    return logic'(ones >= 2);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_prev[d] = 3'b000;
      m_run[d]  = 1;
      m_out[d]  = 1'b0;
    end
  endtask

  task automatic model_edge(logic [2:0] x);
    for (int d = 0; d < 3; d++) begin
      if (m_run[d] >= m_hold[d] + 1) m_out[d] = func_of(d, m_prev[d]);
      if (x == m_prev[d]) begin
        if (m_run[d] < 1000) m_run[d]++;
      end else begin
        m_run[d] = 1;
      end
      m_prev[d] = x;
    end
  endtask

  task automatic check(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t, in=%b)", name, act, exp, $time, in_abc);
    end
  endtask

  task automatic check_model();
    check("model_maj", o_maj, m_out[0]);
    check("model_xor", o_xor, m_out[1]);
    check("model_flt", o_flt, m_out[2]);
  endtask

  // One rising edge; the model sees the same inputs, outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(in_abc);
    @(negedge clk);
    check_model();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset pulse applied mid-cycle, released on a falling edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_maj", o_maj, 1'b0);
    check("async_rst_flt", o_flt, 1'b0);
    check_model();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] in;
    logic       exp_maj;
    logic       exp_xor;
  } vec_t;

  vec_t sweep [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_hold[0] = 0;
    m_hold[1] = 0;
    m_hold[2] = 3;

    sweep[0] = '{3'b000, 1'b0, 1'b0};
    sweep[1] = '{3'b001, 1'b0, 1'b1};
    sweep[2] = '{3'b010, 1'b0, 1'b1};
    sweep[3] = '{3'b011, 1'b1, 1'b0};
    sweep[4] = '{3'b100, 1'b0, 1'b1};
    sweep[5] = '{3'b101, 1'b1, 1'b0};
    sweep[6] = '{3'b110, 1'b1, 1'b0};
    sweep[7] = '{3'b111, 1'b1, 1'b1};

    // Reset asserted with all inputs high: out must be 0 before any clock edge.
    rst_n  = 1'b0;
    in_abc = 3'b111;
    model_reset();
    #2;
    check("rst_maj_pre_clk", o_maj, 1'b0);
    check("rst_xor_pre_clk", o_xor, 1'b0);
    check("rst_flt_pre_clk", o_flt, 1'b0);
    ticks(2);
    rst_n = 1'b1;
    tick();
    check("rel_edge1_maj", o_maj, 1'b0);
    tick();
    check("rel_edge2_maj", o_maj, 1'b1);

    // Exhaustive sweep, each pattern held two edges, twice.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++) begin
        in_abc = sweep[i].in;
        tick();
        tick();
        check("sweep_maj", o_maj, sweep[i].exp_maj);
        check("sweep_xor", o_xor, sweep[i].exp_xor);
      end
    end

    // Filtered step 000 -> 111: out rises exactly 4 edges after capture.
    in_abc = 3'b000;
    ticks(6);
    check("flt_base", o_flt, 1'b0);
    in_abc = 3'b111;
    for (int i = 0; i <= 4; i++) begin
      tick();
      check("flt_step", o_flt, logic'(i == 4));
    end

    // A three-clock 111 pulse is rejected.
    in_abc = 3'b000;
    ticks(6);
    check("flt_pulse_base", o_flt, 1'b0);
    in_abc = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flt_pulse_hi", o_flt, 1'b0);
    end
    in_abc = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("flt_pulse_lo", o_flt, 1'b0);
    end

    // Restart: 011 x2, 110 x2, then 111 held.
    in_abc = 3'b011;
    ticks(2);
    in_abc = 3'b110;
    ticks(2);
    check("flt_restart_mid", o_flt, 1'b0);
    in_abc = 3'b111;
    for (int i = 0; i <= 4; i++) begin
      tick();
      check("flt_restart", o_flt, logic'(i == 4));
    end
    ticks(3);
    check("flt_restart_hold", o_flt, 1'b1);

    // Reset mid-count with out=1 committed, then re-qualify 111.
    in_abc = 3'b000;
    ticks(2);
    check("flt_precnt", o_flt, 1'b1);
    pulse_reset();
    check("flt_after_rst", o_flt, 1'b0);
    in_abc = 3'b111;
    for (int i = 0; i <= 4; i++) begin
      tick();
      check("flt_requal", o_flt, logic'(i == 4));
    end

    // Random stimulus with held runs and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset();
      end else begin
        if ($urandom_range(0, 2) == 0) in_abc = 3'($urandom_range(0, 7));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
